hazard_stall_ctrl: RTL and testbench

//  Drives the enable/clear side of the IF/ID and ID/EX pipeline registers: decides each cycle whether
//  the ID instruction stalls, and keeps the record for each in-flight producer in EX and MEM (dest,

---
 rtl/hazard_stall_ctrl.sv | 99 +++++++++
 tb/tb_hazard_stall_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Stall/bubble control for the IF/ID and ID/EX pipeline registers.
// Tracks EX/MEM producers (dest, Tnew) and the mult/div busy counter.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   ID_rs_i, ID_rt_i      source registers of the instruction in ID
//   ID_TuseRs_i/Rt_i      cycles until each source is consumed (3 = unused)
//   ID_RegAddr_i          destination of the ID instruction (0 = none)
//   ID_Tnew_i             cycles after EX entry until result is forwardable
//   ID_MDStart_i          ID instruction starts a mult/div
//   ID_MDIsDiv_i          start is a div (else mult)
//   ID_MDUse_i            ID instruction touches HI/LO
//   PC_en_o, IFtoID_en_o  freeze PC and IF/ID while stalled
//   IDtoEX_clr_o          load a bubble into ID/EX while stalled
//   Stall_o               stall indicator
//   MD_busy_o             mult/div unit busy
module hazard_stall_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] ID_rs_i,
    input  logic [4:0] ID_rt_i,
    input  logic [1:0] ID_TuseRs_i,
    input  logic [1:0] ID_TuseRt_i,
    input  logic [4:0] ID_RegAddr_i,
    input  logic [1:0] ID_Tnew_i,
    input  logic       ID_MDStart_i,
    input  logic       ID_MDIsDiv_i,
    input  logic       ID_MDUse_i,
    output logic       PC_en_o,
    output logic       IFtoID_en_o,
    output logic       IDtoEX_clr_o,
    output logic       Stall_o,
    output logic       MD_busy_o
);

    logic [4:0]       ex_addr;
    logic [1:0]       ex_tnew;
    logic [4:0]       mem_addr;
    logic [1:0]       mem_tnew;
    logic [CNT_W-1:0] md_cnt;

    logic hz_rs;
    logic hz_rt;
    logic hz_md;

    // A source stalls when a producer still needs more cycles than the
    // consumer can wait; $0 never carries a dependency.
    always_comb begin
        hz_rs = (ID_rs_i != 5'd0) &&
                ((ID_rs_i == ex_addr  && ID_TuseRs_i < ex_tnew) ||
                 (ID_rs_i == mem_addr && ID_TuseRs_i < mem_tnew));
        hz_rt = (ID_rt_i != 5'd0) &&
                ((ID_rt_i == ex_addr  && ID_TuseRt_i < ex_tnew) ||
                 (ID_rt_i == mem_addr && ID_TuseRt_i < mem_tnew));
        hz_md = ID_MDUse_i & MD_busy_o;
    end

    assign MD_busy_o    = (md_cnt != '0);
    assign Stall_o      = hz_rs | hz_rt | hz_md;
    assign PC_en_o      = ~Stall_o;
    assign IFtoID_en_o  = ~Stall_o;
    assign IDtoEX_clr_o = Stall_o;

    // Shadow of the EX/MEM producers; a stall sends a bubble into EX.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_addr  <= 5'd0;
            ex_tnew  <= 2'd0;
            mem_addr <= 5'd0;
            mem_tnew <= 2'd0;
        end else begin
            mem_addr <= ex_addr;
            mem_tnew <= (ex_tnew == 2'd0) ? 2'd0 : ex_tnew - 2'd1;
            if (Stall_o) begin
                ex_addr <= 5'd0;
                ex_tnew <= 2'd0;
            end else begin
                ex_addr <= ID_RegAddr_i;
                ex_tnew <= ID_Tnew_i;
            end
        end
    end

    // A start only loads the counter on the cycle it actually issues.
    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt <= '0;
        end else if (ID_MDStart_i && !Stall_o) begin
            md_cnt <= ID_MDIsDiv_i ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl.
// Drives ID instruction fields and checks stall/busy outputs.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs, rt, dst;
    logic [1:0] trs, trt, tnew;
    logic       md_start, md_isdiv, md_use;
    logic       pc_en, ifid_en, idex_clr, stall, md_busy;

    int n_chk  = 0;
    int n_pass = 0;
    int n;

    always #5 clk = ~clk;

    hazard_stall_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .ID_rs_i      (rs),
        .ID_rt_i      (rt),
        .ID_TuseRs_i  (trs),
        .ID_TuseRt_i  (trt),
        .ID_RegAddr_i (dst),
        .ID_Tnew_i    (tnew),
        .ID_MDStart_i (md_start),
        .ID_MDIsDiv_i (md_isdiv),
        .ID_MDUse_i   (md_use),
        .PC_en_o      (pc_en),
        .IFtoID_en_o  (ifid_en),
        .IDtoEX_clr_o (idex_clr),
        .Stall_o      (stall),
        .MD_busy_o    (md_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [4:0] a_rs, input logic [1:0] a_trs,
                       input logic [4:0] a_rt, input logic [1:0] a_trt,
                       input logic [4:0] a_dst, input logic [1:0] a_tnew,
                       input logic a_start, input logic a_div,
                       input logic a_use);
        rs = a_rs; trs = a_trs; rt = a_rt; trt = a_trt;
        dst = a_dst; tnew = a_tnew;
        md_start = a_start; md_isdiv = a_div; md_use = a_use;
        #1;
    endtask

    task automatic nop;
        put(0, 3, 0, 3, 0, 0, 0, 0, 0);
    endtask

    task automatic flush;
        nop();
        repeat (3) tick();
    endtask

    // Cycles Stall_o stays high while the ID inputs are held.
    task automatic count_stall(output int c);
        c = 0;
        while (stall && c < 40) begin
            c++;
            tick();
        end
    endtask

    task automatic count_busy(output int c);
        c = 0;
        while (md_busy && c < 40) begin
            c++;
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        nop();
        repeat (2) tick();
        reset = 1'b0;
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_pc_en", pc_en, 1);
        chk("rst_ifid_en", ifid_en, 1);
        chk("rst_idex_clr", idex_clr, 0);
        chk("rst_busy", md_busy, 0);

        // T1 load-use
        put(0, 3, 0, 3, 1, 2, 0, 0, 0);
        chk("t1_lw_issue", stall, 0);
        tick();
        put(1, 1, 0, 3, 3, 1, 0, 0, 0);
        chk("t1_lu_stall", stall, 1);
        chk("t1_lu_clr", idex_clr, 1);
        tick();
        chk("t1_lu_release", stall, 0);
        tick();
        flush();

        // T2 load-branch: two cycles
        put(0, 3, 0, 3, 1, 2, 0, 0, 0);
        tick();
        put(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t2_lb_c1", stall, 1);
        tick();
        chk("t2_lb_c2", stall, 1);
        tick();
        chk("t2_lb_rel", stall, 0);
        tick();
        flush();
        // ALU-branch: one cycle
        put(0, 3, 0, 3, 1, 1, 0, 0, 0);
        tick();
        put(1, 0, 0, 3, 0, 0, 0, 0, 0);
        chk("t2_ab_c1", stall, 1);
        tick();
        chk("t2_ab_rel", stall, 0);
        tick();
        flush();

        // T3 $0 writes and unused sources
        put(0, 3, 0, 3, 0, 1, 0, 0, 0);
        tick();
        put(0, 0, 0, 0, 2, 1, 0, 0, 0);
        chk("t3_zero_reg", stall, 0);
        tick();
        put(0, 3, 2, 3, 0, 0, 0, 0, 0);
        chk("t3_tuse3_ex", stall, 0);
        tick();
        flush();

        // T4 mult then mflo
        put(0, 3, 0, 3, 0, 0, 1, 0, 1);
        chk("t4_mult_issue", stall, 0);
        tick();
        put(0, 3, 0, 3, 4, 1, 0, 0, 1);
        chk("t4_mult_busy", md_busy, 1);
        count_stall(n);
        chk("t4_mult_cycles", n, 5);
        chk("t4_mult_idle", md_busy, 0);
        tick();
        flush();
        // div then mflo
        put(0, 3, 0, 3, 0, 0, 1, 1, 1);
        tick();
        put(0, 3, 0, 3, 4, 1, 0, 0, 1);
        count_stall(n);
        chk("t4_div_cycles", n, 10);
        tick();
        flush();
        // mult held in ID by a load-use stall
        put(0, 3, 0, 3, 1, 2, 0, 0, 0);
        tick();
        put(1, 1, 0, 3, 0, 0, 1, 0, 1);
        chk("t4_held_stall", stall, 1);
        tick();
        chk("t4_held_nobusy", md_busy, 0);
        chk("t4_held_issue", stall, 0);
        tick();
        nop();
        count_busy(n);
        chk("t4_held_busy", n, 5);
        flush();

        // T5 reset while div is counting
        put(0, 3, 0, 3, 0, 0, 1, 1, 1);
        tick();
        put(0, 3, 0, 3, 4, 1, 0, 0, 1);
        tick();
        tick();
        chk("t5_pre_stall", stall, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("t5_busy", md_busy, 0);
        chk("t5_stall", stall, 0);
        put(4, 0, 4, 0, 0, 0, 0, 0, 0);
        chk("t5_records", stall, 0);
        flush();

        // T6 simultaneous causes
        put(0, 3, 0, 3, 0, 0, 1, 0, 1);
        tick();
        put(0, 3, 0, 3, 2, 2, 0, 0, 0);
        tick();
        put(0, 3, 0, 3, 1, 2, 0, 0, 0);
        tick();
        put(1, 1, 2, 0, 0, 0, 0, 0, 1);
        chk("t6_stall", stall, 1);
        chk("t6_pc_en", pc_en, 0);
        chk("t6_ifid_en", ifid_en, 0);
        chk("t6_idex_clr", idex_clr, 1);
        count_stall(n);
        chk("t6_cycles", n, 3);
        chk("t6_pc_en_rel", pc_en, 1);
        tick();
        flush();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
